tagged_regfile_mp: RTL
======================

# tagged_regfile_mp

Parametrised, multi-port successor to the single-CDB register file. It holds architectural FP register values plus a per-register producer tag (register status table). It sits between issue, which allocates tags and reads operands, and the result buses (ROB/CDB), which retire values. It adds several broadcast ports, an arbitrary read-port count, flush, a pending-register counter and optional same-cycle forwarding.

## Interface
Parameters:
- NUM_REGS, 32, number of architectural registers
- DATA_W, 64, register data width
- TAG_W, 4, producer tag width; tag 0 = NOTAG
- CDB_PORTS, 2, number of result broadcast ports
- NUM_READ, 2, number of operand read ports

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- stall_i  in  1  blocks tag allocation this cycle
- flush_i  in  1  squash: clear every pending tag
- alloc_valid_i  in  1  rename request
- alloc_reg_i  in  $clog2(NUM_REGS)  destination register
- alloc_tag_i  in  TAG_W  producer tag to record
- rd_addr_i  in  NUM_READ*$clog2(NUM_REGS)  source register per read port
- rd_ign_tag_i  in  NUM_READ  per port: force rd_tag_o to NOTAG (branch/jump operand not needed)
- rd_data_o  out  NUM_READ*DATA_W  operand value
- rd_tag_o  out  NUM_READ*TAG_W  pending producer tag, 0 if value valid
- cdb_valid_i  in  CDB_PORTS  broadcast valid
- cdb_tag_i  in  CDB_PORTS*TAG_W  broadcast tag
- cdb_data_i  in  CDB_PORTS*DATA_W  broadcast value
- busy_cnt_o  out  $clog2(NUM_REGS+1)  number of registers with nonzero tag
- tb_regs_o  out  NUM_REGS*DATA_W  flattened register values, reg i at [i*DATA_W +: DATA_W]

## Operation
- Reset (rst_n low, asynchronous): all values 0, all tags 0, busy_cnt_o 0. Read outputs follow state combinationally, so they read 0.
- Allocation: if alloc_valid_i && !stall_i && !flush_i && alloc_tag_i != 0, then Tags[alloc_reg_i] <= alloc_tag_i. alloc_tag_i == 0 is a no-op. The caller filters store tags.
- Writeback: for each entry with Tags[r] != 0, if any port p has cdb_valid_i[p] && cdb_tag_i[p] == Tags[r], then Regs[r] <= cdb_data_i[p] and Tags[r] <= 0. If several ports match, the lowest p wins. Valid ports carrying tag 0 are ignored.
- Same-cycle alloc and writeback on the same register: the writeback value is stored and the tag becomes alloc_tag_i, because the new producer wins.
- Flush: all tags become 0 on the edge. Writebacks in the same cycle still update values. Allocation is suppressed.
- Reads are combinational from current state. An allocation in the same cycle is not visible until the next cycle, so a source equal to the destination returns the old tag.
- rd_tag_o[k] = 0 if rd_ign_tag_i[k], else Tags[rd_addr_i[k]]. rd_data_o is always Regs[...], unless forwarded (see Configuration).
- busy_cnt_o is registered and always equals the popcount of nonzero tags after each edge.

## Timing
- Read latency: 0 cycles, combinational.
- Allocate and writeback take effect at the next rising edge. The result is visible on reads in the cycle after that edge.
- stall_i affects allocation only. Writeback is never stalled.
- Reset asserted mid-operation discards all pending tags immediately. There is no replay.

## Configuration
- TRF_BYPASS_EN defined: combinational forwarding on the read path. If the read tag is nonzero and a valid CDB port carries that tag this cycle, rd_data_o = that port's data (lowest port wins) and rd_tag_o = 0.
- TRF_BYPASS_EN undefined: no forwarding. The consumer sees the value one cycle after the broadcast.

## Structure
- Package trf_pkg: NOTAG constant; tag_t/data_t typedefs; reservation station tag constants (ADD_1..3 = 1..3, MULT_1..2 = 4..5, LD_1..3 = 6..8, ST_1..2 = 9..10).
- Sub-module trf_cdb_match: given one tag and all CDB ports, returns hit and selected data with lowest-port priority. It is instantiated per entry and per read port when bypass is enabled.

## Test plan
- Reset mid-run with r5 tag = 3 pending: rst_n low -> tag 0, value 0, busy_cnt_o 0 without a clock edge.
- Alloc r5 tag 3, then CDB port 1 tag 3 data 0xAB -> next cycle r5 = 0xAB, tag 0, busy_cnt_o 1->0.
- Same cycle: CDB tag 3 data 0x11 and alloc r5 tag 4, with r5 tag = 3 -> r5 = 0x11, tag 4, busy_cnt_o stays 1.
- Two ports both carry tag 2 (data 0x5 on port 0, 0x9 on port 1) -> register takes 0x5.
- flush_i with 4 tagged registers plus a concurrent alloc -> all tags 0, busy_cnt_o 0, alloc dropped. stall_i alone with alloc -> tag unchanged.
- TRF_BYPASS_EN: read r2 (tag 6) while CDB broadcasts tag 6 data 0x77 -> rd_data_o 0x77, rd_tag_o 0 in the same cycle. Without the macro -> tag 6 that cycle, 0x77 next cycle. rd_ign_tag_i set -> rd_tag_o 0.

Source files
------------

// File: rtl/trf_pkg.sv
// Shared types and constants for the tagged register file.
package trf_pkg;

  localparam int unsigned TRF_TAG_W  = 4;
  localparam int unsigned TRF_DATA_W = 64;

  typedef logic [TRF_TAG_W-1:0]  tag_t;
  typedef logic [TRF_DATA_W-1:0] data_t;

  // Tag 0 marks a register whose value is architecturally valid.
  localparam tag_t NOTAG  = 4'd0;

  // Reservation-station producer tags.
  localparam tag_t ADD_1  = 4'd1;
  localparam tag_t ADD_2  = 4'd2;
  localparam tag_t ADD_3  = 4'd3;
  localparam tag_t MULT_1 = 4'd4;
  localparam tag_t MULT_2 = 4'd5;
  localparam tag_t LD_1   = 4'd6;
  localparam tag_t LD_2   = 4'd7;
  localparam tag_t LD_3   = 4'd8;
  localparam tag_t ST_1   = 4'd9;
  localparam tag_t ST_2   = 4'd10;

endpackage

// File: rtl/trf_cdb_match.sv
// Matches one producer tag against every result bus; lowest port wins.
module trf_cdb_match
  import trf_pkg::*;
#(
  parameter int unsigned TAG_W     = 4,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned CDB_PORTS = 2
) (
  input  logic [TAG_W-1:0]            tag,
  input  logic [CDB_PORTS-1:0]        cdb_valid,
  input  logic [CDB_PORTS*TAG_W-1:0]  cdb_tag,
  input  logic [CDB_PORTS*DATA_W-1:0] cdb_data,
  output logic                        hit_c,
  output logic [DATA_W-1:0]           data_c
);

  // Scan from the highest port down so the lowest matching port is left last.
  always_comb begin
    hit_c  = 1'b0;
    data_c = '0;
    for (int p = int'(CDB_PORTS) - 1; p >= 0; p--) begin
      if (tag != TAG_W'(NOTAG) && cdb_valid[p] && cdb_tag[p*TAG_W +: TAG_W] == tag) begin
        hit_c  = 1'b1;
        data_c = cdb_data[p*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/tagged_regfile_mp.sv
// Multi-port tagged FP register file with register status table.
// Optional same-cycle read forwarding from the result buses: TRF_BYPASS_EN.
module tagged_regfile_mp
  import trf_pkg::*;
#(
  parameter int unsigned NUM_REGS  = 32,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned TAG_W     = 4,
  parameter int unsigned CDB_PORTS = 2,
  parameter int unsigned NUM_READ  = 2,
  localparam int unsigned AW       = $clog2(NUM_REGS),
  localparam int unsigned CW       = $clog2(NUM_REGS + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          stall_i,
  input  logic                          flush_i,
  input  logic                          alloc_valid_i,
  input  logic [AW-1:0]                 alloc_reg_i,
  input  logic [TAG_W-1:0]              alloc_tag_i,
  input  logic [NUM_READ*AW-1:0]        rd_addr_i,
  input  logic [NUM_READ-1:0]           rd_ign_tag_i,
  output logic [NUM_READ*DATA_W-1:0]    rd_data_o,
  output logic [NUM_READ*TAG_W-1:0]     rd_tag_o,
  input  logic [CDB_PORTS-1:0]          cdb_valid_i,
  input  logic [CDB_PORTS*TAG_W-1:0]    cdb_tag_i,
  input  logic [CDB_PORTS*DATA_W-1:0]   cdb_data_i,
  output logic [CW-1:0]                 busy_cnt_o,
  output logic [NUM_REGS*DATA_W-1:0]    tb_regs_o
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [TAG_W-1:0]  tags_q [NUM_REGS];
  logic [TAG_W-1:0]  tags_d [NUM_REGS];
  logic [CW-1:0]     busy_q;
  logic [CW-1:0]     busy_d;
  logic [NUM_REGS-1:0] wb_hit;
  logic [DATA_W-1:0] wb_data [NUM_REGS];

  // Per-entry writeback matcher against the broadcast ports.
  for (genvar r = 0; r < int'(NUM_REGS); r++) begin : g_wb
    trf_cdb_match #(
      .TAG_W(TAG_W), .DATA_W(DATA_W), .CDB_PORTS(CDB_PORTS)
    ) u_match (
      .tag       (tags_q[r]),
      .cdb_valid (cdb_valid_i),
      .cdb_tag   (cdb_tag_i),
      .cdb_data  (cdb_data_i),
      .hit_c     (wb_hit[r]),
      .data_c    (wb_data[r])
    );
    assign tb_regs_o[r*DATA_W +: DATA_W] = regs_q[r];
  end

  // Next state: writeback first, then flush or allocation overrides the tag.
  always_comb begin
    regs_d = regs_q;
    tags_d = tags_q;
    busy_d = '0;
    for (int r = 0; r < int'(NUM_REGS); r++) begin
      if (wb_hit[r]) begin
        regs_d[r] = wb_data[r];
        tags_d[r] = TAG_W'(NOTAG);
      end
    end
    if (flush_i) begin
      for (int r = 0; r < int'(NUM_REGS); r++) tags_d[r] = TAG_W'(NOTAG);
    end else if (alloc_valid_i && !stall_i && alloc_tag_i != TAG_W'(NOTAG)) begin
      tags_d[alloc_reg_i] = alloc_tag_i;
    end
    for (int r = 0; r < int'(NUM_REGS); r++) begin
      busy_d = busy_d + CW'(tags_d[r] != TAG_W'(NOTAG));
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < int'(NUM_REGS); r++) begin
        regs_q[r] <= '0;
        tags_q[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      tags_q <= tags_d;
      busy_q <= busy_d;
    end
  end

  assign busy_cnt_o = busy_q;

  // Operand read ports, combinational from current state.
  for (genvar k = 0; k < int'(NUM_READ); k++) begin : g_rd
    logic [AW-1:0]     addr;
    logic [TAG_W-1:0]  tag_s;
    logic [DATA_W-1:0] data_s;
    assign addr   = rd_addr_i[k*AW +: AW];
    assign tag_s  = tags_q[addr];
    assign data_s = regs_q[addr];
`ifdef TRF_BYPASS_EN
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    trf_cdb_match #(
      .TAG_W(TAG_W), .DATA_W(DATA_W), .CDB_PORTS(CDB_PORTS)
    ) u_fwd (
      .tag       (tag_s),
      .cdb_valid (cdb_valid_i),
      .cdb_tag   (cdb_tag_i),
      .cdb_data  (cdb_data_i),
      .hit_c     (fwd_hit),
      .data_c    (fwd_data)
    );
    assign rd_data_o[k*DATA_W +: DATA_W] = fwd_hit ? fwd_data : data_s;
    assign rd_tag_o[k*TAG_W +: TAG_W]    = (rd_ign_tag_i[k] || fwd_hit) ? TAG_W'(NOTAG) : tag_s;
`else
    assign rd_data_o[k*DATA_W +: DATA_W] = data_s;
    assign rd_tag_o[k*TAG_W +: TAG_W]    = rd_ign_tag_i[k] ? TAG_W'(NOTAG) : tag_s;
`endif
  end

endmodule
